// File: rtl/name_det_pkg.sv
// rtl/name_det_pkg.sv - shared constants, state encoding and ASCII case folding for the name detector
package name_det_pkg;

    // Upper-case letter bounds. Lower-case letters are the same codes with
    // bit 5 set, and that bit on its own is the blank character.
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_Z     = 8'h5A;
    localparam logic [7:0] CH_BLANK = 8'h20;

    // Armed/fill view of the detector.
    typedef enum logic [1:0] {
        ST_UNARMED = 2'd0,  // pattern length is zero
        ST_FILLING = 2'd1,  // not enough fresh characters for a full compare
        ST_HUNTING = 2'd2   // the next accepted character can complete a match
    } det_state_e;

    // Folds 'a'-'z' onto 'A'-'Z'. Only meaningful for 8-bit characters;
    // any other width is passed through untouched.
    function automatic logic [7:0] fold_char(input logic [7:0] c, input logic en,
                                             input int char_w);
        if (en && (char_w == 8) && (c >= (CH_A | CH_BLANK)) && (c <= (CH_Z | CH_BLANK)))
            return c & ~CH_BLANK;
        return c;
    endfunction

endpackage

// File: rtl/char_fold.sv
// rtl/char_fold.sv - combinational ASCII case folder with enable
// Ports:
//   i_en   : 1 = fold lower-case letters to upper case
//   i_char : character in
//   o_char : folded character out (identity when CHAR_W != 8)
module char_fold
    import name_det_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic              i_en,
    input  logic [CHAR_W-1:0] i_char,
    output logic [CHAR_W-1:0] o_char
);

    generate
        if (CHAR_W == 8) begin : g_ascii
            assign o_char = fold_char(i_char, i_en, CHAR_W);
        end else begin : g_raw
            assign o_char = i_char;
        end
    endgenerate

endmodule

// File: rtl/name_detector_prog.sv
// rtl/name_detector_prog.sv - programmable streaming character-sequence detector
// Ports:
//   clk, rst (async, active low)
//   cfg_we/cfg_addr/cfg_char : pattern slot write
//   cfg_len_we/cfg_len       : active pattern length load (clamped to MAX_LEN)
//   overlap_en, case_insens  : detection modes
//   in_valid/in_char         : character stream
//   cnt_clr                  : clear of the match counter
//   match, match_cnt, armed  : registered pulse, saturating count, length nonzero
module name_detector_prog
    import name_det_pkg::*;
#(
    parameter  int CHAR_W  = 8,
    parameter  int MAX_LEN = 16,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CHAR_W-1:0] cfg_char,
    input  logic              cfg_len_we,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              overlap_en,
    input  logic              case_insens,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              cnt_clr,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              armed
);

    logic [CHAR_W-1:0] r_pat  [MAX_LEN];
    logic [CHAR_W-1:0] r_hist [MAX_LEN];
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_fill;
    logic              r_match;
    logic [CNT_W-1:0]  r_cnt;
    det_state_e        r_state;
    det_state_e        w_state_nxt;

    logic              w_cfg;
    logic              w_accept;
    logic              w_all_eq;
    logic              w_hit;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [LEN_W-1:0]  w_fill_nxt;
    logic [CHAR_W-1:0] w_view   [MAX_LEN];
    logic [CHAR_W-1:0] w_view_f [MAX_LEN];
    logic [CHAR_W-1:0] w_pat_f  [MAX_LEN];

    // Any configuration write flushes the history and wins over the input.
    assign w_cfg    = cfg_we | cfg_len_we;
    assign w_accept = in_valid & ~w_cfg;

    // Post-shift view: slot 0 is the character arriving now, slot i the one
    // accepted i positions ago.
    assign w_view[0] = in_char;
    generate
        for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_view
            assign w_view[gi] = r_hist[gi-1];
        end
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_fold
            char_fold #(.CHAR_W(CHAR_W)) u_fold_view (
                .i_en(case_insens), .i_char(w_view[gi]), .o_char(w_view_f[gi]));
            char_fold #(.CHAR_W(CHAR_W)) u_fold_pat (
                .i_en(case_insens), .i_char(r_pat[gi]), .o_char(w_pat_f[gi]));
        end
    endgenerate

    // Pattern slot k lines up with the character accepted (len-1-k) ago.
    always_comb begin
        w_all_eq = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(r_len)) begin
                if (w_pat_f[k] != w_view_f[ADDR_W'(int'(r_len) - 1 - k)])
                    w_all_eq = 1'b0;
            end
        end
    end

    // HUNTING already encodes armed and fill+1 >= len.
    assign w_hit = w_accept & (r_state == ST_HUNTING) & w_all_eq;

    always_comb begin
        w_len_nxt = r_len;
        if (cfg_len_we)
            w_len_nxt = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    end

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_cfg)
            w_fill_nxt = '0;
        else if (w_accept) begin
            if (w_hit && !overlap_en)
                w_fill_nxt = '0;
            else if (r_fill != LEN_W'(MAX_LEN))
                w_fill_nxt = r_fill + LEN_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_UNARMED;
        else      r_state <= w_state_nxt;
    end

    // Next state, derived from the length and fill that take effect this edge.
    always_comb begin
        w_state_nxt = ST_FILLING;
        if (w_len_nxt == '0)
            w_state_nxt = ST_UNARMED;
        else if ((LEN_W+1)'(w_fill_nxt) + (LEN_W+1)'(1) >= (LEN_W+1)'(w_len_nxt))
            w_state_nxt = ST_HUNTING;
    end

    // State outputs.
    always_comb begin
        armed = (r_state != ST_UNARMED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_pat[i]  <= '0;
                r_hist[i] <= '0;
            end
            r_len   <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (cfg_we && (int'(cfg_addr) < MAX_LEN))
                r_pat[cfg_addr] <= cfg_char;
            if (w_accept) begin
                r_hist[0] <= in_char;
                for (int i = 1; i < MAX_LEN; i++)
                    r_hist[i] <= r_hist[i-1];
            end
            r_len   <= w_len_nxt;
            r_fill  <= w_fill_nxt;
            r_match <= w_hit;
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_hit && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;

endmodule
